// File: rtl/tagged_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : tagged_data_memory
// Brief    : Tag-selected multi-region data RAM with byte/half/word access,
//            big-endian lanes, programmable wait states, req/ready/valid
//            handshake and sticky fault capture.
// Revision : 1.0 - initial release
// ============================================================================
module tagged_data_memory #(
  parameter int          N_REGIONS   = 3,
  parameter logic [63:0] REGION_TAGS = 64'h0000_2000_7fff_1000,
  parameter int          ADDR_WORDS  = 10,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_in,
  input  logic        we_in,
  input  logic [31:0] addr_in,
  input  logic [1:0]  size_in,
  input  logic        signed_in,
  input  logic [31:0] writedata_in,
  input  logic        clear_fault_in,
  output logic        ready_out,
  output logic        valid_out,
  output logic [31:0] readdata_out,
  output logic        fault_out,
  output logic        fault_sticky_out,
  output logic [31:0] fault_addr_out
);

  localparam int         DEPTH    = 1 << ADDR_WORDS;
  localparam int         RW       = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [3:0]            wait_cnt;
  logic                  accept, enter_resp;

  // Request captured at accept; used when the access completes after wait states
  logic                  we_q, signed_q;
  logic [31:0]           addr_q, wdata_q;
  logic [1:0]            size_q;

  // Operands of the access completing on this edge
  logic                  acc_we, acc_signed;
  logic [31:0]           acc_addr, acc_wdata;
  logic [1:0]            acc_size;

  logic                  hit, fault;
  logic [RW-1:0]         region;
  logic [ADDR_WORDS-1:0] word_idx;
  logic [3:0]            be;
  logic [31:0]           lane_data, rd_word, load_data;
  logic                  unused_addr_bits;

  logic [31:0]           mem [N_REGIONS][DEPTH];

  assign ready_out = (state == ST_IDLE);
  assign accept    = req_in & ready_out;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; enter_resp marks the edge on which memory is accessed
  always_comb begin
    state_next = state;
    enter_resp = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_next = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_next = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Zero wait states complete straight from IDLE, so use the live request there
  always_comb begin
    acc_we     = we_q;
    acc_addr   = addr_q;
    acc_size   = size_q;
    acc_signed = signed_q;
    acc_wdata  = wdata_q;
    if (state == ST_IDLE) begin
      acc_we     = we_in;
      acc_addr   = addr_in;
      acc_size   = size_in;
      acc_signed = signed_in;
      acc_wdata  = writedata_in;
    end
  end

  // Region decode: scan downward so the lowest matching index wins
  always_comb begin
    hit    = 1'b0;
    region = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (acc_addr[31:16] == REGION_TAGS[16*i +: 16]) begin
        hit    = 1'b1;
        region = RW'(i);
      end
    end
  end

  assign word_idx         = acc_addr[ADDR_WORDS+1:2];
  assign unused_addr_bits = ^acc_addr[15:ADDR_WORDS+2];

  assign fault = !hit
               || (acc_size == 2'b10)
               || (acc_size == 2'b01 && acc_addr[0])
               || (acc_size == 2'b11 && acc_addr[1:0] != 2'b00);

  // Byte enables and replicated store data; lane 3 holds the lowest byte address
  always_comb begin
    be        = 4'b1111;
    lane_data = acc_wdata;
    case (acc_size)
      2'b00: begin
        be        = 4'b1000 >> acc_addr[1:0];
        lane_data = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        be        = acc_addr[1] ? 4'b0011 : 4'b1100;
        lane_data = {2{acc_wdata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        lane_data = acc_wdata;
      end
    endcase
  end

  assign rd_word = mem[region][word_idx];

  // Load extraction: right-justify the selected lanes and extend
  always_comb begin
    load_data = rd_word;
    case (acc_size)
      2'b00: begin
        case (acc_addr[1:0])
          2'd0:    load_data = {{24{acc_signed & rd_word[31]}}, rd_word[31:24]};
          2'd1:    load_data = {{24{acc_signed & rd_word[23]}}, rd_word[23:16]};
          2'd2:    load_data = {{24{acc_signed & rd_word[15]}}, rd_word[15:8]};
          default: load_data = {{24{acc_signed & rd_word[7]}},  rd_word[7:0]};
        endcase
      end
      2'b01: begin
        if (acc_addr[1]) load_data = {{16{acc_signed & rd_word[15]}}, rd_word[15:0]};
        else             load_data = {{16{acc_signed & rd_word[31]}}, rd_word[31:16]};
      end
      default: load_data = rd_word;
    endcase
  end

  // RAM write port: lane-masked store on the edge entering RESP, never on a fault
  always_ff @(posedge clock) begin
    if (enter_resp && acc_we && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[region][word_idx][8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
  end

  // Request capture and wait-state countdown
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      wdata_q  <= 32'd0;
    end else if (accept) begin
      wait_cnt <= CNT_INIT;
      we_q     <= we_in;
      addr_q   <= addr_in;
      size_q   <= size_in;
      signed_q <= signed_in;
      wdata_q  <= writedata_in;
    end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Registered response and fault capture; a new fault beats a same-edge clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_out        <= 1'b0;
      fault_out        <= 1'b0;
      readdata_out     <= 32'd0;
      fault_sticky_out <= 1'b0;
      fault_addr_out   <= 32'd0;
    end else begin
      valid_out <= enter_resp;
      fault_out <= enter_resp & fault;
      if (enter_resp) readdata_out <= (fault || acc_we) ? 32'd0 : load_data;
      if (enter_resp && fault) begin
        fault_sticky_out <= 1'b1;
        fault_addr_out   <= acc_addr;
      end else if (clear_fault_in) begin
        fault_sticky_out <= 1'b0;
        fault_addr_out   <= 32'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tagged_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_tagged_data_memory
// Brief    : Self-checking bench: byte-addressed big-endian reference model
//            for a zero-wait instance, directed checks for a 3-wait instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tagged_data_memory;

  localparam int          AW        = 10;
  localparam logic [31:0] WRAP_MASK = 32'hFFFF_0000 | ((32'h1 << (AW + 2)) - 32'h1);

  logic        clock = 1'b0;
  logic        rst0, rst3;
  logic        req, we, sgn, clr;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        ready, valid, flt, sticky;
  logic [31:0] rdata, faddr;
  logic        req3, we3, sgn3, clr3;
  logic [31:0] addr3, wdata3;
  logic [1:0]  size3;
  logic        ready3, valid3, flt3, sticky3;
  logic [31:0] rdata3, faddr3;

  int checks = 0;
  int errors = 0;

  // Expected outputs of the zero-wait instance
  logic        e_ready, e_valid, e_fault, e_sticky;
  logic [31:0] e_rd, e_faddr;
  logic        cmp_on;
  logic        cap_valid, cap_fault;
  logic [31:0] cap_rd;
  logic        cap3_fault;
  logic [31:0] cap3_rd;

  logic [7:0]  mbytes [logic [31:0]];

  always #5 clock = ~clock;

  tagged_data_memory #(.N_REGIONS(3), .REGION_TAGS(64'h0000_2000_7fff_1000),
                       .ADDR_WORDS(AW), .WAIT_STATES(0)) dut (
    .clock(clock), .reset(rst0), .req_in(req), .we_in(we), .addr_in(addr),
    .size_in(size), .signed_in(sgn), .writedata_in(wdata), .clear_fault_in(clr),
    .ready_out(ready), .valid_out(valid), .readdata_out(rdata), .fault_out(flt),
    .fault_sticky_out(sticky), .fault_addr_out(faddr));

  tagged_data_memory #(.N_REGIONS(3), .REGION_TAGS(64'h0000_2000_7fff_1000),
                       .ADDR_WORDS(AW), .WAIT_STATES(3)) dut3 (
    .clock(clock), .reset(rst3), .req_in(req3), .we_in(we3), .addr_in(addr3),
    .size_in(size3), .signed_in(sgn3), .writedata_in(wdata3), .clear_fault_in(clr3),
    .ready_out(ready3), .valid_out(valid3), .readdata_out(rdata3), .fault_out(flt3),
    .fault_sticky_out(sticky3), .fault_addr_out(faddr3));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] canon(input logic [31:0] a);
    return a & WRAP_MASK;
  endfunction

  // Reference: memory as big-endian bytes; lowest address is the most significant
  task automatic model_access(input logic w, input logic [31:0] a, input logic [1:0] s,
                              input logic sg, input logic [31:0] d,
                              output logic f, output logic [31:0] r);
    int n;
    logic [31:0] v;
    f = !(a[31:16] inside {16'h1000, 16'h7fff, 16'h2000}) || (s == 2'b10)
        || (s == 2'b01 && a[0]) || (s == 2'b11 && a[1:0] != 2'b00);
    n = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    r = 32'd0;
    if (!f) begin
      if (w) begin
        for (int k = 0; k < n; k++) mbytes[canon(a + 32'(k))] = d[8*(n-1-k) +: 8];
      end else begin
        v = 32'd0;
        for (int k = 0; k < n; k++) v = {v[23:0], mbytes[canon(a + 32'(k))]};
        if (sg && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
        r = v;
      end
    end
  endtask

  // One access on the zero-wait instance; called just after a rising edge in IDLE
  task automatic access(input logic w, input logic [31:0] a, input logic [1:0] s,
                        input logic sg, input logic [31:0] d, input logic c);
    logic f;
    logic [31:0] r;
    req = 1'b1; we = w; addr = a; size = s; sgn = sg; wdata = d; clr = c;
    @(posedge clock); #1;
    req = 1'b0; clr = 1'b0;
    model_access(w, a, s, sg, d, f, r);
    e_ready = 1'b0; e_valid = 1'b1; e_fault = f; e_rd = r;
    if (f) begin
      e_sticky = 1'b1; e_faddr = a;
    end else if (c) begin
      e_sticky = 1'b0; e_faddr = 32'd0;
    end
    @(negedge clock);
    cap_valid = valid; cap_fault = flt; cap_rd = rdata;
    @(posedge clock); #1;
    e_ready = 1'b1; e_valid = 1'b0; e_fault = 1'b0;
  endtask

  task automatic clear_fault();
    clr = 1'b1;
    @(posedge clock); #1;
    clr = 1'b0; e_sticky = 1'b0; e_faddr = 32'd0;
  endtask

  // One access on the 3-wait instance, with a bounded wait for the response
  task automatic access3(input logic w, input logic [31:0] a, input logic [1:0] s,
                         input logic [31:0] d);
    bit found = 0;
    req3 = 1'b1; we3 = w; addr3 = a; size3 = s; sgn3 = 1'b0; wdata3 = d;
    @(posedge clock); #1;
    req3 = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clock);
      if (valid3) begin
        found = 1; cap3_fault = flt3; cap3_rd = rdata3;
      end
    end
    chk("ws3_response_seen", 32'(found), 32'd1);
    @(posedge clock); #1;
  endtask

  // Every cycle the zero-wait instance is out of reset its outputs must match the model
  always @(negedge clock) begin
    if (cmp_on) begin
      chk("ready", 32'(ready), 32'(e_ready));
      chk("valid", 32'(valid), 32'(e_valid));
      chk("fault", 32'(flt), 32'(e_fault));
      chk("readdata", rdata, e_rd);
      chk("sticky", 32'(sticky), 32'(e_sticky));
      chk("fault_addr", faddr, e_faddr);
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int vcount;
    rst0 = 1'b1; rst3 = 1'b1; cmp_on = 1'b0;
    req = 0; we = 0; addr = 0; size = 0; sgn = 0; wdata = 0; clr = 0;
    req3 = 0; we3 = 0; addr3 = 0; size3 = 0; sgn3 = 0; wdata3 = 0; clr3 = 0;
    e_ready = 1; e_valid = 0; e_fault = 0; e_rd = 0; e_sticky = 0; e_faddr = 0;
    cap_valid = 0; cap_fault = 0; cap_rd = 0; cap3_fault = 0; cap3_rd = 0;
    repeat (3) @(posedge clock);
    #1;
    rst0 = 1'b0; rst3 = 1'b0; cmp_on = 1'b1;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_readdata", rdata, 32'd0);
    chk("reset_sticky", 32'(sticky), 32'd0);

    // Word store/load
    access(1, 32'h1000_0004, 2'b11, 0, 32'hDEAD_BEEF, 0);
    chk("store_valid", 32'(cap_valid), 32'd1);
    chk("store_readdata_zero", cap_rd, 32'd0);
    access(0, 32'h1000_0004, 2'b11, 0, 32'd0, 0);
    chk("load_word", cap_rd, 32'hDEAD_BEEF);
    chk("load_word_nofault", 32'(cap_fault), 32'd0);

    // Byte lanes and extension
    access(1, 32'h7fff_0000, 2'b11, 0, 32'h1122_3344, 0);
    access(1, 32'h7fff_0002, 2'b00, 0, 32'h0000_0080, 0);
    access(0, 32'h7fff_0002, 2'b00, 1, 32'd0, 0);
    chk("load_byte_signed", cap_rd, 32'hFFFF_FF80);
    access(0, 32'h7fff_0002, 2'b00, 0, 32'd0, 0);
    chk("load_byte_unsigned", cap_rd, 32'h0000_0080);
    access(0, 32'h7fff_0000, 2'b11, 0, 32'd0, 0);
    chk("byte_lanes_kept", cap_rd, 32'h1122_8044);
    access(0, 32'h7fff_0000, 2'b01, 1, 32'd0, 0);
    chk("load_half_hi", cap_rd, 32'h0000_1122);
    access(0, 32'h7fff_0002, 2'b01, 1, 32'd0, 0);
    chk("load_half_lo_signed", cap_rd, 32'hFFFF_8044);
    access(0, 32'h7fff_0001, 2'b00, 0, 32'd0, 0);
    chk("load_byte1", cap_rd, 32'h0000_0022);

    // Half store in low lanes
    access(1, 32'h2000_0004, 2'b11, 0, 32'h0000_0000, 0);
    access(1, 32'h2000_0006, 2'b01, 0, 32'hFFFF_ABCD, 0);
    access(0, 32'h2000_0004, 2'b11, 0, 32'd0, 0);
    chk("half_store_lanes", cap_rd, 32'h0000_ABCD);

    // Misaligned faults leave memory alone
    access(0, 32'h1000_0003, 2'b01, 0, 32'd0, 0);
    chk("misalign_valid", 32'(cap_valid), 32'd1);
    chk("misalign_fault", 32'(cap_fault), 32'd1);
    chk("misalign_readdata", cap_rd, 32'd0);
    chk("misalign_addr", faddr, 32'h1000_0003);
    access(1, 32'h1000_0005, 2'b01, 0, 32'h0000_FFFF, 0);
    access(0, 32'h1000_0004, 2'b11, 0, 32'd0, 0);
    chk("fault_no_write", cap_rd, 32'hDEAD_BEEF);

    clear_fault();
    chk("cleared_sticky", 32'(sticky), 32'd0);

    // Unmapped access with a same-edge clear: the fault wins
    access(0, 32'h3000_0000, 2'b11, 0, 32'd0, 1);
    chk("unmapped_sticky", 32'(sticky), 32'd1);
    chk("unmapped_addr", faddr, 32'h3000_0000);
    access(0, 32'h1000_0004, 2'b10, 0, 32'd0, 0);
    chk("reserved_size_addr", faddr, 32'h1000_0004);

    // Wrap within region
    access(1, 32'h1000_1004, 2'b11, 0, 32'h55AA_55AA, 0);
    access(0, 32'h1000_0004, 2'b11, 0, 32'd0, 0);
    chk("wrap_word1", cap_rd, 32'h55AA_55AA);
    access(0, 32'h1000_0007, 2'b00, 1, 32'd0, 0);
    chk("wrap_byte3_signed", cap_rd, 32'hFFFF_FFAA);

    // Three wait states: response exactly in cycle 4, held request not re-accepted
    req3 = 1'b1; we3 = 1'b1; addr3 = 32'h1000_0008; size3 = 2'b11; wdata3 = 32'hCAFE_F00D;
    vcount = 0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clock); #1;
      if (k == 4) req3 = 1'b0;
      @(negedge clock);
      if (valid3) vcount++;
      if (k == 1) chk("ws3_ready_wait", 32'(ready3), 32'd0);
      if (k == 3) chk("ws3_valid_c3", 32'(valid3), 32'd0);
      if (k == 4) chk("ws3_valid_c4", 32'(valid3), 32'd1);
      if (k == 5) chk("ws3_ready_idle", 32'(ready3), 32'd1);
    end
    chk("ws3_one_response", 32'(vcount), 32'd1);
    @(posedge clock); #1;

    access3(0, 32'h3000_0000, 2'b11, 32'd0);
    chk("ws3_unmapped_fault", 32'(cap3_fault), 32'd1);
    access3(0, 32'h1000_0008, 2'b11, 32'd0);
    chk("ws3_load", cap3_rd, 32'hCAFE_F00D);

    // Reset during the wait of a store discards it
    req3 = 1'b1; we3 = 1'b1; addr3 = 32'h1000_0008; size3 = 2'b11; wdata3 = 32'h1234_5678;
    @(posedge clock); #1;
    req3 = 1'b0;
    @(negedge clock);
    rst3 = 1'b1;
    #1;
    chk("ws3_rst_ready", 32'(ready3), 32'd1);
    chk("ws3_rst_valid", 32'(valid3), 32'd0);
    chk("ws3_rst_readdata", rdata3, 32'd0);
    chk("ws3_rst_fault", 32'(flt3), 32'd0);
    chk("ws3_rst_sticky", 32'(sticky3), 32'd0);
    chk("ws3_rst_faddr", faddr3, 32'd0);
    @(posedge clock); #1;
    rst3 = 1'b0;
    vcount = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (valid3) vcount++;
    end
    chk("ws3_no_stale_response", 32'(vcount), 32'd0);
    @(posedge clock); #1;
    access3(0, 32'h1000_0008, 2'b11, 32'd0);
    chk("ws3_old_data", cap3_rd, 32'hCAFE_F00D);

    repeat (2) @(posedge clock);
    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
